// File: rtl/varredura_display_pkg.sv
// Shared definitions for the two-digit display scan controller.
// Holds the scan state encoding, the active-low digit enable patterns
// for the common-anode board and the aux select values, so that the
// display manager and its bench can reuse them.
package pkg_display;

    // Scan states, in the order they are visited.
    typedef enum logic [1:0] {
        APAGA_A = 2'b00,   // blank before the actions digit
        ACOES   = 2'b01,   // actions digit lit
        APAGA_V = 2'b10,   // blank before the speed digit
        VELOC   = 2'b11    // speed digit lit
    } estado_t;

    // Active-low digit enables; bits 3:2 are unused digits, kept off.
    localparam logic [3:0] DIGITO_OFF   = 4'b1111;
    localparam logic [3:0] DIGITO_ACOES = 4'b1110;
    localparam logic [3:0] DIGITO_VELOC = 4'b1101;

    // Digit select towards the display manager.
    localparam logic AUX_ACOES = 1'b0;
    localparam logic AUX_VELOC = 1'b1;

    // Digit enable pattern shown in each state.
    function automatic logic [3:0] digito_de(input estado_t e);
        logic [3:0] d;
        d = DIGITO_OFF;
        case (e)
            ACOES:   d = DIGITO_ACOES;
            VELOC:   d = DIGITO_VELOC;
            default: d = DIGITO_OFF;
        endcase
        return d;
    endfunction

    // aux belongs to the digit about to be (or being) shown, so it flips
    // on entry to the blank state that precedes that digit.
    function automatic logic aux_de(input estado_t e);
        return (e == APAGA_V || e == VELOC) ? AUX_VELOC : AUX_ACOES;
    endfunction

endpackage

// File: rtl/varredura_display_if.sv
// Display scan bus.
//   habilita : scan enable (driven by the controlling side)
//   aux      : digit select, 0 = actions, 1 = speed
//   digito   : active-low digit enables, bit0 actions, bit1 speed
//   quadro   : one-cycle end-of-frame pulse
// master = the side that enables the scan and consumes its outputs,
// slave  = the scan controller itself.
interface varredura_display_if;
    logic       habilita;
    logic       aux;
    logic [3:0] digito;
    logic       quadro;

    modport master (output habilita, input aux, input digito, input quadro);
    modport slave  (input habilita, output aux, output digito, output quadro);
endinterface

// File: rtl/varredura_display_contador.sv
// contador_varredura: terminal-count counter for the scan controller.
//   clk   : system clock
//   clr   : synchronous clear, forces cnt to 0 (has priority)
//   limit : number of cycles per period for the current state
//   fim   : high while cnt == limit-1 (last cycle of the period)
// The counter reloads 0 by itself after its last cycle, so it never runs
// past the limit even if the owner forgets to clear it.
module contador_varredura #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W:0]   limit,
    output logic             fim
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // limit is one bit wider than cnt so a limit of exactly 2^CNT_W fits.
    assign fim = ({1'b0, cnt_reg} == (limit - (CNT_W+1)'(1)));

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clr || fim) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        cnt_reg <= cnt_next;
    end

endmodule

// File: rtl/varredura_display.sv
// varredura_display: scan controller for the two-digit multiplexed
// 7-segment display.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of varredura_display_if
//           (habilita in; aux, digito, quadro out)
// Cycles APAGA_A -> ACOES -> APAGA_V -> VELOC, with all digits off during
// the APAGA states so the aux mux settles without ghosting. All outputs
// are registered and follow the registered state.
module varredura_display
    import pkg_display::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    varredura_display_if.slave   bus
);

    localparam logic [CNT_W:0] LIM_BLANK = (CNT_W+1)'(BLANK_CYCLES);
    localparam logic [CNT_W:0] LIM_LIT   = (CNT_W+1)'(REFRESH_DIV);

    estado_t        state_reg;
    estado_t        state_next;
    logic [CNT_W:0] limit;
    logic           fim;
    logic           clr;

    logic [3:0]     digito_reg, digito_next;
    logic           aux_reg,    aux_next;
    logic           quadro_reg, quadro_next;

    // Blank states last BLANK_CYCLES, lit states REFRESH_DIV.
    assign limit = state_reg[0] ? LIM_LIT : LIM_BLANK;

    // Every state entry starts the count from 0; fim already covers the
    // normal transitions, reset and disable force it.
    assign clr = reset || !bus.habilita || fim;

    contador_varredura #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk   (clk),
        .clr   (clr),
        .limit (limit),
        .fim   (fim)
    );

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= APAGA_A;
            digito_reg <= DIGITO_OFF;
            aux_reg    <= AUX_ACOES;
            quadro_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            digito_reg <= digito_next;
            aux_reg    <= aux_next;
            quadro_reg <= quadro_next;
        end
    end

    // Next-state logic: disable sends the scan back to the start.
    always_comb begin
        state_next = state_reg;
        if (!bus.habilita) begin
            state_next = APAGA_A;
        end else if (fim) begin
            case (state_reg)
                APAGA_A: state_next = ACOES;
                ACOES:   state_next = APAGA_V;
                APAGA_V: state_next = VELOC;
                VELOC:   state_next = APAGA_A;
                default: state_next = APAGA_A;
            endcase
        end
    end

    // Output logic, computed from the state being entered so the
    // registered outputs line up with the registered state.
    always_comb begin
        digito_next = digito_de(state_next);
        aux_next    = aux_de(state_next);
        // Frame pulse only for the natural VELOC -> APAGA_A wrap; a
        // simultaneous disable wins and suppresses it.
        quadro_next = bus.habilita && fim && (state_reg == VELOC);
    end

    assign bus.digito = digito_reg;
    assign bus.aux    = aux_reg;
    assign bus.quadro = quadro_reg;

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display with REFRESH_DIV=4, BLANK_CYCLES=2.
// A frame-position model pushes the expected {digito,aux,quadro} for
// every driven cycle; each scenario pops and compares after the edge.
module tb_varredura_display;
    import pkg_display::*;

    localparam int RD     = 4;
    localparam int BL     = 2;
    localparam int PERIOD = 2 * (RD + BL);

    logic clk;
    logic reset;
    varredura_display_if bus ();

    varredura_display #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pos    = 0;     // position inside the frame, 0 = first blank cycle
    logic q_mod = 1'b0;
    logic [5:0] sb[$];  // expected {digito, aux, quadro}
    logic [5:0] got;
    logic [5:0] exp_v;

    function automatic logic [5:0] modelo(input int p, input logic q);
        logic [3:0] d;
        logic       a;
        if (p < BL) begin
            d = 4'b1111; a = 1'b0;
        end else if (p < BL + RD) begin
            d = 4'b1110; a = 1'b0;
        end else if (p < 2 * BL + RD) begin
            d = 4'b1111; a = 1'b1;
        end else begin
            d = 4'b1101; a = 1'b1;
        end
        return {d, a, q};
    endfunction

    // Drive one cycle, predict what the outputs show after the edge.
    task automatic drive(input logic r, input logic h);
        reset        = r;
        bus.habilita = h;
        if (r || !h) begin
            q_mod = 1'b0;
            pos   = 0;
        end else begin
            q_mod = (pos == PERIOD - 1);
            pos   = (pos + 1) % PERIOD;
        end
        sb.push_back(modelo(pos, q_mod));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 1));
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v || got !== 6'b1111_0_0) begin
                errors++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, got, exp_v);
            end else $display("ok reset i=%0d out=%b", i, got);
        end
    endtask

    // Cycle n (n>=2) is observed after the (n-1)th enabled drive.
    task automatic test_frame;
        for (int n = 2; n <= 30; n++) begin
            drive(1'b0, 1'b1);
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL frame cyc=%0d got=%b exp=%b", n, got, exp_v);
            end else $display("ok frame cyc=%0d out=%b", n, got);
            if (n == 13 || n == 25) begin
                checks++;
                if (got !== 6'b1111_0_1) begin
                    errors++;
                    $display("FAIL frame_pulse cyc=%0d got=%b exp=111101", n, got);
                end
            end
        end
    endtask

    task automatic test_reset_mid_veloc;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int n = 2; n <= 10; n++) begin
            drive(1'b0, 1'b1);
            void'(sb.pop_front());
        end
        checks++;
        if (bus.digito !== 4'b1101) begin
            errors++;
            $display("FAIL mid_veloc_pre got=%b exp=1101", bus.digito);
        end
        drive(1'b1, 1'b1);
        got = {bus.digito, bus.aux, bus.quadro};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v || got !== 6'b1111_0_0) begin
            errors++;
            $display("FAIL mid_veloc_reset got=%b exp=%b", got, exp_v);
        end else $display("ok mid_veloc_reset out=%b", got);
        for (int n = 2; n <= 14; n++) begin
            drive(1'b0, 1'b1);
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL mid_veloc_restart cyc=%0d got=%b exp=%b", n, got, exp_v);
            end else $display("ok mid_veloc_restart cyc=%0d out=%b", n, got);
        end
    endtask

    task automatic test_habilita_gap;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int n = 0; n < 22; n++) begin
            drive(1'b0, !(n >= 3 && n < 8));
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL habilita_gap step=%0d got=%b exp=%b", n, got, exp_v);
            end else $display("ok habilita_gap step=%0d out=%b", n, got);
        end
    endtask

    task automatic test_veloc_disable;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int n = 2; n <= 12; n++) begin
            drive(1'b0, 1'b1);
            void'(sb.pop_front());
        end
        drive(1'b0, 1'b0);
        got = {bus.digito, bus.aux, bus.quadro};
        exp_v = sb.pop_front();
        checks++;
        if (got !== exp_v || bus.quadro !== 1'b0) begin
            errors++;
            $display("FAIL veloc_disable got=%b exp=%b", got, exp_v);
        end else $display("ok veloc_disable out=%b", got);
        for (int n = 0; n < 13; n++) begin
            drive(1'b0, 1'b1);
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL veloc_reenable step=%0d got=%b exp=%b", n, got, exp_v);
            end else $display("ok veloc_reenable step=%0d out=%b", n, got);
        end
    endtask

    task automatic test_random;
        logic [5:0] prev;
        prev = {bus.digito, bus.aux, bus.quadro};
        for (int n = 0; n < 10000; n++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) != 0));
            got = {bus.digito, bus.aux, bus.quadro};
            exp_v = sb.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random n=%0d got=%b exp=%b", n, got, exp_v);
            end else $display("ok random n=%0d out=%b", n, got);
            checks++;
            if (!(got[5:2] == 4'b1111 || got[5:2] == 4'b1110 || got[5:2] == 4'b1101)
                || (got[5:2] != 4'b1111 && prev[5:2] != 4'b1111 && got[1] !== prev[1])
                || (got[0] && prev[0])) begin
                errors++;
                $display("FAIL random_invariant n=%0d got=%b prev=%b", n, got, prev);
            end
            prev = got;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.habilita = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_frame;
        test_reset_mid_veloc;
        test_habilita_gap;
        test_veloc_disable;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
